cordic_arbiter: RTL and testbench

Shares one iterative CORDIC engine between `NUM_REQ` independent requesters. Each requester submits a job (mode, rotate/vector select, fixed-point position, two operands) over a valid/ready handshake. The arbiter grants jobs round-robin, drives the engine's start pulse and operand buses, and returns the engine's two outputs to the granted requester over a valid/ready response channel. A watchdog converts a missing engine `done` into an error response, so a requester can never hang.

---
 rtl/cordic_arbiter.sv | 154 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC engine between NUM_REQ requesters.
// One job in flight; a watchdog turns a missing engine done into an error response.
module cordic_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FIXED_WIDTH = 16,
  parameter int SHIFT_W     = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ-1:0]             req_rot,
  input  logic [SHIFT_W*NUM_REQ-1:0]     req_shift,
  input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [FIXED_WIDTH-1:0]         rsp_out1,
  output logic [FIXED_WIDTH-1:0]         rsp_out2,
  output logic                           rsp_err,
  output logic                           eng_start,
  output logic [1:0]                     eng_mode,
  output logic                           eng_is_rotating,
  output logic [SHIFT_W-1:0]             eng_shift,
  output logic [FIXED_WIDTH-1:0]         eng_a,
  output logic [FIXED_WIDTH-1:0]         eng_b,
  input  logic [FIXED_WIDTH-1:0]         eng_out1,
  input  logic [FIXED_WIDTH-1:0]         eng_out2,
  input  logic                           eng_done,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]             r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_grant;
  logic [1:0]             r_mode;
  logic                   r_rot;
  logic [SHIFT_W-1:0]     r_shift;
  logic [FIXED_WIDTH-1:0] r_a;
  logic [FIXED_WIDTH-1:0] r_b;
  logic [FIXED_WIDTH-1:0] r_out1;
  logic [FIXED_WIDTH-1:0] r_out2;
  logic                   r_err;
  logic [WD_W-1:0]        r_wdog;

  logic                   w_found;
  logic [PTR_W-1:0]       w_grant;

  function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int offs);
    if (int'(base) + offs >= NUM_REQ)
      return PTR_W'(int'(base) + offs - NUM_REQ);
    else
      return PTR_W'(int'(base) + offs);
  endfunction

  // Walk from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrapIdx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_grant = wrapIdx(r_ptr, k);
      end
    end
  end

  assign req_ready       = (r_state == S_IDLE && w_found) ? (ONE << w_grant) : '0;
  assign rsp_valid       = (r_state == S_RESP) ? (ONE << r_grant) : '0;
  assign rsp_out1        = r_out1;
  assign rsp_out2        = r_out2;
  assign rsp_err         = r_err;
  assign eng_start       = (r_state == S_ISSUE);
  assign eng_mode        = r_mode;
  assign eng_is_rotating = r_rot;
  assign eng_shift       = r_shift;
  assign eng_a           = r_a;
  assign eng_b           = r_b;
  assign busy            = (r_state != S_IDLE);

  // Job registers feed the engine directly, so they only change on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_mode  <= '0;
      r_rot   <= 1'b0;
      r_shift <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_err   <= 1'b0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_grant;
            r_mode  <= req_mode[2*w_grant +: 2];
            r_rot   <= req_rot[w_grant];
            r_shift <= req_shift[SHIFT_W*w_grant +: SHIFT_W];
            r_a     <= req_a[FIXED_WIDTH*w_grant +: FIXED_WIDTH];
            r_b     <= req_b[FIXED_WIDTH*w_grant +: FIXED_WIDTH];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as a real result.
          if (eng_done) begin
            r_out1  <= eng_out1;
            r_out2  <= eng_out2;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            r_out1  <= '0;
            r_out2  <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_grant]) begin
            r_ptr   <= wrapIdx(r_grant, 1);
            r_out1  <= '0;
            r_out2  <= '0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural engine that finishes
// ten cycles after its start pulse (out1 = a*b >> shift, out2 = a+b).
module tb_cordic_arbiter;

  localparam int NUM_REQ = 2;
  localparam int FW      = 16;
  localparam int SW      = 4;
  localparam int TIMEOUT = 32;
  localparam logic [1:0] LINEAR = 2'd1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_mode;
  logic [NUM_REQ-1:0]    req_rot;
  logic [SW*NUM_REQ-1:0] req_shift;
  logic [FW*NUM_REQ-1:0] req_a;
  logic [FW*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [FW-1:0]         rsp_out1;
  logic [FW-1:0]         rsp_out2;
  logic                  rsp_err;
  logic                  eng_start;
  logic [1:0]            eng_mode;
  logic                  eng_is_rotating;
  logic [SW-1:0]         eng_shift;
  logic [FW-1:0]         eng_a;
  logic [FW-1:0]         eng_b;
  logic [FW-1:0]         eng_out1;
  logic [FW-1:0]         eng_out2;
  logic                  eng_done;
  logic                  busy;

  logic                  mdlDone;
  logic                  manualDone;
  logic                  engineOn;
  int                    mdlCnt;
  int                    vectors;
  int                    miscompares;
  logic                  got;

  cordic_arbiter #(
    .NUM_REQ(NUM_REQ), .FIXED_WIDTH(FW), .SHIFT_W(SW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_rot(req_rot), .req_shift(req_shift), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_is_rotating(eng_is_rotating),
    .eng_shift(eng_shift), .eng_a(eng_a), .eng_b(eng_b),
    .eng_out1(eng_out1), .eng_out2(eng_out2), .eng_done(eng_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign eng_done = mdlDone | manualDone;

  // Engine stand-in: done lands ten cycles after the start pulse.
  always @(posedge clk) begin
    mdlDone <= 1'b0;
    if (!rst_n) begin
      mdlCnt <= 0;
    end else if (eng_start && engineOn) begin
      mdlCnt <= 9;
    end else if (mdlCnt != 0) begin
      mdlCnt <= mdlCnt - 1;
      if (mdlCnt == 1) begin
        mdlDone  <= 1'b1;
        eng_out1 <= FW'((32'(eng_a) * 32'(eng_b)) >> eng_shift);
        eng_out2 <= eng_a + eng_b;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global time limit reached");
  end

  function automatic logic [NUM_REQ-1:0] oneHot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] mode, input logic rot,
                               input logic [SW-1:0] shift, input logic [FW-1:0] a,
                               input logic [FW-1:0] b);
    req_mode[2*idx +: 2]   = mode;
    req_rot[idx]           = rot;
    req_shift[SW*idx +: SW] = shift;
    req_a[FW*idx +: FW]    = a;
    req_b[FW*idx +: FW]    = b;
    req_valid[idx]         = 1'b1;
  endtask

  // Called at a falling edge while IDLE; runs one job through to its handshake.
  task automatic serveOne(input int expIdx, input logic [FW-1:0] expOut1,
                          input logic expErr, input bit keep);
    logic seen;
    seen = 1'b0;
    #1;
    checkOutput("grant", 32'(req_ready), 32'(oneHot(expIdx)));
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (!keep) req_valid[expIdx] = 1'b0;
      #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    checkOutput("rspSeen", 32'(seen), 32'd1);
    checkOutput("rspIndex", 32'(rsp_valid), 32'(oneHot(expIdx)));
    checkOutput("rspOut1", 32'(rsp_out1), 32'(expOut1));
    checkOutput("rspErr", 32'(rsp_err), 32'(expErr));
    rsp_ready = '1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checkOutput("rspDrop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_mode    = '0;
    req_rot     = '0;
    req_shift   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = '0;
    manualDone  = 1'b0;
    engineOn    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstReqReady", 32'(req_ready), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstEngStart", 32'(eng_start), 32'd0);
    checkOutput("rstEngA", 32'(eng_a), 32'd0);
    checkOutput("rstRspOut1", 32'(rsp_out1), 32'd0);
    rst_n = 1'b1;

    // Single linear multiply with exact latency
    @(negedge clk);
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    #1;
    checkOutput("t1Ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("t1Start", 32'(eng_start), 32'd1);
    checkOutput("t1EngA", 32'(eng_a), 32'h0800);
    checkOutput("t1EngB", 32'(eng_b), 32'h0600);
    checkOutput("t1EngShift", 32'(eng_shift), 32'd10);
    checkOutput("t1EngMode", 32'(eng_mode), 32'(LINEAR));
    checkOutput("t1EngRot", 32'(eng_is_rotating), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("t1NoEarlyRsp", 32'(rsp_valid), 32'd0);
    checkOutput("t1StartOnce", 32'(eng_start), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("t1RspValid", 32'(rsp_valid), 32'h1);
    checkOutput("t1Out1", 32'(rsp_out1), 32'h0C00);
    checkOutput("t1Out2", 32'(rsp_out2), 32'h0E00);
    checkOutput("t1Err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checkOutput("t1Drop", 32'(rsp_valid), 32'd0);
    checkOutput("t1DropOut1", 32'(rsp_out1), 32'd0);
    checkOutput("t1Idle", 32'(busy), 32'd0);

    // Simultaneous requests alternate after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    applyStimulus(1, LINEAR, 1'b1, 4'd10, 16'h0400, 16'h0300);
    serveOne(0, 16'h0C00, 1'b0, 1'b1);
    serveOne(1, 16'h0300, 1'b0, 1'b1);
    serveOne(0, 16'h0C00, 1'b0, 1'b1);
    serveOne(1, 16'h0300, 1'b0, 1'b1);

    // Response backpressure: requester 1 waits behind a held response
    #1;
    checkOutput("t3Grant0", 32'(req_ready), 32'h1);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      if (rsp_valid != '0) got = 1'b1;
    end
    checkOutput("t3RspSeen", 32'(got), 32'd1);
    for (int c = 0; c < 20; c++) begin
      checkOutput("t3HoldValid", 32'(rsp_valid), 32'h1);
      checkOutput("t3HoldOut1", 32'(rsp_out1), 32'h0C00);
      checkOutput("t3NoGrant1", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 2'b01;
    #1;
    checkOutput("t3HsNoGrant", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checkOutput("t3Drop", 32'(rsp_valid), 32'd0);
    serveOne(1, 16'h0300, 1'b0, 1'b0);

    // Watchdog timeout with the engine silent
    engineOn = 1'b0;
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    #1;
    checkOutput("t4Ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("t4Start", 32'(eng_start), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    #1;
    checkOutput("t4NoEarlyRsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("t4RspValid", 32'(rsp_valid), 32'h1);
    checkOutput("t4Err", 32'(rsp_err), 32'd1);
    checkOutput("t4Out1", 32'(rsp_out1), 32'd0);
    checkOutput("t4Out2", 32'(rsp_out2), 32'd0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    engineOn  = 1'b1;
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    serveOne(0, 16'h0C00, 1'b0, 1'b0);

    // Reset during WAIT drops the job and clears the pointer
    applyStimulus(1, LINEAR, 1'b1, 4'd10, 16'h0400, 16'h0300);
    #1;
    checkOutput("t5Ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t5BusyWait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t5Busy", 32'(busy), 32'd0);
    checkOutput("t5RspValid", 32'(rsp_valid), 32'd0);
    checkOutput("t5EngA", 32'(eng_a), 32'd0);
    checkOutput("t5EngB", 32'(eng_b), 32'd0);
    checkOutput("t5EngShift", 32'(eng_shift), 32'd0);
    checkOutput("t5EngMode", 32'(eng_mode), 32'd0);
    checkOutput("t5EngRot", 32'(eng_is_rotating), 32'd0);
    checkOutput("t5EngStart", 32'(eng_start), 32'd0);
    checkOutput("t5ReqReady", 32'(req_ready), 32'd0);
    checkOutput("t5Err", 32'(rsp_err), 32'd0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      checkOutput("t5NoRsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    applyStimulus(1, LINEAR, 1'b1, 4'd10, 16'h0400, 16'h0300);
    serveOne(0, 16'h0C00, 1'b0, 1'b0);
    serveOne(1, 16'h0300, 1'b0, 1'b0);

    // Stale done in IDLE and in the ISSUE cycle is ignored
    manualDone = 1'b1;
    #1;
    checkOutput("t6IdleBusy", 32'(busy), 32'd0);
    @(negedge clk);
    manualDone = 1'b0;
    #1;
    checkOutput("t6IdleStill", 32'(busy), 32'd0);
    checkOutput("t6IdleNoRsp", 32'(rsp_valid), 32'd0);
    engineOn = 1'b0;
    applyStimulus(0, LINEAR, 1'b1, 4'd10, 16'h0800, 16'h0600);
    @(negedge clk);
    req_valid  = '0;
    manualDone = 1'b1;
    #1;
    checkOutput("t6Start", 32'(eng_start), 32'd1);
    @(negedge clk);
    manualDone = 1'b0;
    #1;
    checkOutput("t6NoRsp", 32'(rsp_valid), 32'd0);
    checkOutput("t6StillBusy", 32'(busy), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    #1;
    checkOutput("t6TimeoutValid", 32'(rsp_valid), 32'h1);
    checkOutput("t6TimeoutErr", 32'(rsp_err), 32'd1);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    engineOn  = 1'b1;
    #1;
    checkOutput("t6Idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
